// File: rtl/regmap_arbiter_if.sv
// Bus bundle around the regmap arbiter: I2C slave port, local requester, regmap.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface regmap_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic              i2c_wr_pulse;
  logic              i2c_active;
  logic [DATA_W-1:0] i2c_rdata;
  logic              i2c_wr_overrun;
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic              loc_rvalid;
  logic [DATA_W-1:0] loc_rdata;
  logic              rm_en;
  logic              rm_we;
  logic [ADDR_W-1:0] rm_addr;
  logic [DATA_W-1:0] rm_wdata;
  logic [DATA_W-1:0] rm_rdata;

  modport slave (
    input  i2c_addr, i2c_wdata, i2c_wr_pulse, i2c_active,
    input  loc_req, loc_we, loc_addr, loc_wdata, rm_rdata,
    output i2c_rdata, i2c_wr_overrun, loc_gnt, loc_rvalid,
    output loc_rdata, rm_en, rm_we, rm_addr, rm_wdata
  );

  modport master (
    output i2c_addr, i2c_wdata, i2c_wr_pulse, i2c_active,
    output loc_req, loc_we, loc_addr, loc_wdata, rm_rdata,
    input  i2c_rdata, i2c_wr_overrun, loc_gnt, loc_rvalid,
    input  loc_rdata, rm_en, rm_we, rm_addr, rm_wdata
  );
endinterface

// File: rtl/regmap_arbiter.sv
// Serialises I2C-slave and local accesses onto the single-port regmap and
// keeps i2c_rdata prefetched from the current I2C address.
module regmap_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  regmap_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] act_sync;
  logic                   wr_s_d;
  logic                   act_s_d;
  logic [ADDR_W-1:0]      addr_sync [SYNC_STAGES];
  logic [ADDR_W-1:0]      addr_s_d;
  logic [ADDR_W-1:0]      stable_addr;

  logic wr_s;
  logic act_s;
  logic wr_rise;
  logic act_rise;

  assign wr_s     = wr_sync[SYNC_STAGES-1];
  assign act_s    = act_sync[SYNC_STAGES-1];
  assign wr_rise  = wr_s & ~wr_s_d;
  assign act_rise = act_s & ~act_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync     <= '0;
      act_sync    <= '0;
      wr_s_d      <= 1'b0;
      act_s_d     <= 1'b0;
      addr_s_d    <= '0;
      stable_addr <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        addr_sync[i] <= '0;
    end else begin
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus.i2c_wr_pulse};
      act_sync <= {act_sync[SYNC_STAGES-2:0], bus.i2c_active};
      wr_s_d   <= wr_s;
      act_s_d  <= act_s;
      addr_sync[0] <= bus.i2c_addr;
      for (int i = 1; i < SYNC_STAGES; i++)
        addr_sync[i] <= addr_sync[i-1];
      addr_s_d <= addr_sync[SYNC_STAGES-1];
      // per-bit syncs can skew; only trust a value seen twice in a row
      if (addr_sync[SYNC_STAGES-1] == addr_s_d)
        stable_addr <= addr_s_d;
    end
  end

  state_t            state;
  logic              wr_pend;
  logic              pf_pend;
  logic              last_wr;
  logic              rd_loc;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] pf_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] loc_rdata_q;

  logic idle;
  logic pf_need;
  logic take_wr;
  logic take_loc;
  logic take_pf;
  logic wr_hits_pf;

  assign idle     = (state == IDLE);
  assign pf_need  = pf_pend | (idle & (stable_addr != pf_addr_q));
  assign take_wr  = idle & wr_pend & (~bus.loc_req | ~last_wr);
  assign take_loc = idle & bus.loc_req & (~wr_pend | last_wr);
  assign take_pf  = idle & pf_need & ~wr_pend & ~bus.loc_req;

  assign wr_hits_pf = (state == ISSUE) & bus.rm_we &
                      (bus.rm_addr == pf_addr_q);

  assign bus.loc_rdata = bus.loc_rvalid ? bus.rm_rdata : loc_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      wr_pend            <= 1'b0;
      pf_pend            <= 1'b0;
      last_wr            <= 1'b0;
      rd_loc             <= 1'b0;
      wr_addr_q          <= '0;
      wr_data_q          <= '0;
      pf_addr_q          <= '0;
      rd_addr_q          <= '0;
      loc_rdata_q        <= '0;
      bus.i2c_rdata      <= '0;
      bus.i2c_wr_overrun <= 1'b0;
      bus.loc_gnt        <= 1'b0;
      bus.loc_rvalid     <= 1'b0;
      bus.rm_en          <= 1'b0;
      bus.rm_we          <= 1'b0;
      bus.rm_addr        <= '0;
      bus.rm_wdata       <= '0;
    end else begin
      bus.loc_gnt    <= 1'b0;
      bus.loc_rvalid <= 1'b0;
      bus.rm_en      <= 1'b0;
      bus.rm_we      <= 1'b0;
      bus.rm_addr    <= '0;
      bus.rm_wdata   <= '0;

      if (wr_rise) begin
        wr_addr_q <= bus.i2c_addr;
        wr_data_q <= bus.i2c_wdata;
      end
      if (wr_rise & wr_pend & ~take_wr)
        bus.i2c_wr_overrun <= 1'b1;
      if (take_wr)
        wr_pend <= 1'b0;
      if (wr_rise)
        wr_pend <= 1'b1;

      if (take_pf)
        pf_pend <= 1'b0;
      else if (pf_need)
        pf_pend <= 1'b1;
      if (wr_hits_pf | act_rise)
        pf_pend <= 1'b1;

      // fairness flips only when both requesters actually contend
      if (idle & wr_pend & bus.loc_req)
        last_wr <= take_wr;

      unique case (state)
        IDLE: begin
          unique case (1'b1)
            take_wr: begin
              state        <= ISSUE;
              bus.rm_en    <= 1'b1;
              bus.rm_we    <= 1'b1;
              bus.rm_addr  <= wr_addr_q;
              bus.rm_wdata <= wr_data_q;
            end
            take_loc: begin
              state        <= ISSUE;
              bus.loc_gnt  <= 1'b1;
              bus.rm_en    <= 1'b1;
              bus.rm_we    <= bus.loc_we;
              bus.rm_addr  <= bus.loc_addr;
              bus.rm_wdata <= bus.loc_we ? bus.loc_wdata : '0;
              rd_loc       <= 1'b1;
              rd_addr_q    <= bus.loc_addr;
            end
            take_pf: begin
              state       <= ISSUE;
              bus.rm_en   <= 1'b1;
              bus.rm_addr <= stable_addr;
              rd_loc      <= 1'b0;
              rd_addr_q   <= stable_addr;
            end
            default: state <= IDLE;
          endcase
        end
        ISSUE: begin
          if (bus.rm_we) begin
            state <= IDLE;
          end else begin
            state          <= RD_WAIT;
            bus.loc_rvalid <= rd_loc;
          end
        end
        RD_WAIT: begin
          state <= IDLE;
          if (rd_loc) begin
            loc_rdata_q <= bus.rm_rdata;
          end else begin
            bus.i2c_rdata <= bus.rm_rdata;
            pf_addr_q     <= rd_addr_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regmap_arbiter.sv
// Bench for regmap_arbiter: directed scenarios plus randomized I2C/local
// traffic against a regmap array and a reference memory image.
module tb_regmap_arbiter;
  logic clk;
  logic rst;

  regmap_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  regmap_arbiter #(
    .ADDR_W(8),
    .DATA_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (bus.rm_en) begin
      if (bus.rm_we) mem[bus.rm_addr] <= bus.rm_wdata;
      else           bus.rm_rdata <= mem[bus.rm_addr];
    end
  end

  int n_chk;
  int n_pass;
  int idle_viol;
  int n_gnt;
  int n_rv;
  logic [7:0] wr_log [$];
  logic [7:0] wd_log [$];
  logic [7:0] rd_log [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.rm_en && (bus.rm_we || bus.rm_addr != 8'h00 ||
                         bus.rm_wdata != 8'h00))
        idle_viol++;
      if (bus.rm_en && bus.rm_we) begin
        wr_log.push_back(bus.rm_addr);
        wd_log.push_back(bus.rm_wdata);
      end
      if (bus.rm_en && !bus.rm_we) rd_log.push_back(bus.rm_addr);
      if (bus.loc_gnt) n_gnt++;
      if (bus.loc_rvalid) n_rv++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_logs();
    @(posedge clk);
    wr_log.delete();
    wd_log.delete();
    rd_log.delete();
    @(negedge clk);
  endtask

  function automatic logic [63:0] out_vec();
    return {27'd0, bus.i2c_rdata, bus.i2c_wr_overrun, bus.loc_gnt,
            bus.loc_rvalid, bus.loc_rdata, bus.rm_en, bus.rm_we,
            bus.rm_addr, bus.rm_wdata};
  endfunction

  task automatic wait_gnt(input int bound, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.loc_gnt && lat < bound);
  endtask

  task automatic loc_op(input bit we, input logic [7:0] a,
                        input logic [7:0] d, output int lat);
    logic [7:0] exp;
    exp = ref_mem[a];
    bus.loc_req   = 1'b1;
    bus.loc_we    = we;
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    wait_gnt(40, lat);
    bus.loc_req = 1'b0;
    if (!bus.loc_gnt) begin
      chk("loc_gnt_timeout", 0, 1);
      return;
    end
    if (we) begin
      ref_mem[a] = d;
    end else begin
      @(negedge clk);
      chk("loc_rvalid", bus.loc_rvalid, 1);
      chk("loc_rdata", bus.loc_rdata, exp);
    end
  endtask

  task automatic i2c_wr(input logic [7:0] a, input logic [7:0] d,
                        input int bound);
    bit seen;
    int lat;
    bus.i2c_addr  = a;
    bus.i2c_wdata = d;
    cyc(3);
    bus.i2c_wr_pulse = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (!seen && bus.rm_en && bus.rm_we && bus.rm_addr == a &&
          bus.rm_wdata == d) begin
        seen = 1'b1;
        lat  = n + 1;
      end
    end
    bus.i2c_wr_pulse = 1'b0;
    chk("i2c_wr_lat", (seen && lat <= bound), 1);
    ref_mem[a] = d;
    cyc(16);
  endtask

  task automatic collide(input logic [7:0] ia, input logic [7:0] id,
                         input logic [7:0] exp_first,
                         input logic [7:0] exp_second);
    int lat;
    bus.i2c_addr  = ia;
    bus.i2c_wdata = id;
    cyc(20);
    clr_logs();
    bus.i2c_wr_pulse = 1'b1;
    cyc(3);
    bus.loc_req   = 1'b1;
    bus.loc_we    = 1'b1;
    bus.loc_addr  = 8'h04;
    bus.loc_wdata = 8'h11;
    wait_gnt(20, lat);
    chk("t3_gnt", bus.loc_gnt, 1);
    bus.loc_req = 1'b0;
    bus.loc_we  = 1'b0;
    cyc(14);
    bus.i2c_wr_pulse = 1'b0;
    cyc(16);
    @(posedge clk);
    chk("t3_nwr", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      chk("t3_first", wr_log[0], exp_first);
      chk("t3_second", wr_log[1], exp_second);
    end
    ref_mem[ia]    = id;
    ref_mem[8'h04] = 8'h11;
    @(negedge clk);
  endtask

  int lat;
  int rv0;
  int gnt0;
  int nrd;
  int mism;
  int hits;
  logic [7:0] pa;

  initial begin
    n_chk = 0; n_pass = 0; idle_viol = 0; n_gnt = 0; n_rv = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5C;
      ref_mem[i] = 8'(i) ^ 8'h5C;
    end
    mem[8'h03] = 8'hC3; ref_mem[8'h03] = 8'hC3;
    mem[8'h21] = 8'h77; ref_mem[8'h21] = 8'h77;
    rst = 1'b1;
    bus.i2c_addr = 8'h00; bus.i2c_wdata = 8'h00;
    bus.i2c_wr_pulse = 1'b0; bus.i2c_active = 1'b0;
    bus.loc_req = 1'b0; bus.loc_we = 1'b0;
    bus.loc_addr = 8'h00; bus.loc_wdata = 8'h00;
    cyc(3);
    chk("reset_outputs", out_vec(), 0);
    rst = 1'b0;
    cyc(4);

    // I2C write with no local traffic
    clr_logs();
    i2c_wr(8'h10, 8'h5A, 6);
    @(posedge clk);
    chk("t1_nwr", wr_log.size(), 1);
    if (wr_log.size() >= 1) begin
      chk("t1_addr", wr_log[0], 8'h10);
      chk("t1_data", wd_log[0], 8'h5A);
    end
    chk("t1_overrun", bus.i2c_wr_overrun, 0);
    @(negedge clk);
    chk("t1_prefetch_new", bus.i2c_rdata, 8'h5A);

    // local read while idle
    @(posedge clk);
    rv0 = n_rv;
    @(negedge clk);
    loc_op(1'b0, 8'h03, 8'h00, lat);
    chk("t2_gnt_lat", lat, 1);
    cyc(4);
    @(posedge clk);
    chk("t2_rvalid_once", n_rv - rv0, 1);
    @(negedge clk);

    // collisions: I2C first (last served LOC), then local first
    collide(8'h30, 8'hE1, 8'h30, 8'h04);
    collide(8'h30, 8'hE2, 8'h04, 8'h30);

    // prefetch follows an address step and a local write to it
    bus.i2c_addr = 8'h20;
    cyc(20);
    clr_logs();
    bus.i2c_addr = 8'h21;
    cyc(8);
    chk("t4_prefetch", bus.i2c_rdata, 8'h77);
    cyc(12);
    @(posedge clk);
    hits = 0;
    foreach (rd_log[i]) if (rd_log[i] == 8'h21) hits++;
    chk("t4_one_read", hits, 1);
    @(negedge clk);
    loc_op(1'b1, 8'h21, 8'h99, lat);
    cyc(10);
    chk("t4_refetch", bus.i2c_rdata, 8'h99);

    // two write edges while a local read is in flight
    bus.i2c_addr  = 8'h40;
    bus.i2c_wdata = 8'hA1;
    cyc(20);
    clr_logs();
    bus.i2c_wr_pulse = 1'b1;
    @(negedge clk);
    bus.i2c_wr_pulse = 1'b0;
    @(negedge clk);
    bus.i2c_wr_pulse = 1'b1;
    bus.loc_req  = 1'b1;
    bus.loc_we   = 1'b0;
    bus.loc_addr = 8'h90;
    @(negedge clk);
    chk("t5_gnt", bus.loc_gnt, 1);
    bus.loc_req   = 1'b0;
    bus.i2c_addr  = 8'h41;
    bus.i2c_wdata = 8'hB2;
    @(negedge clk);
    chk("t5_rvalid", bus.loc_rvalid, 1);
    chk("t5_rdata", bus.loc_rdata, ref_mem[8'h90]);
    cyc(14);
    bus.i2c_wr_pulse = 1'b0;
    cyc(16);
    @(posedge clk);
    chk("t5_overrun", bus.i2c_wr_overrun, 1);
    chk("t5_nwr", wr_log.size(), 1);
    if (wr_log.size() >= 1) begin
      chk("t5_addr", wr_log[0], 8'h41);
      chk("t5_data", wd_log[0], 8'hB2);
    end
    ref_mem[8'h41] = 8'hB2;
    @(negedge clk);

    // reset while a local read sits in RD_WAIT
    bus.loc_req  = 1'b1;
    bus.loc_we   = 1'b0;
    bus.loc_addr = 8'h91;
    wait_gnt(20, lat);
    chk("t6_gnt", bus.loc_gnt, 1);
    @(posedge clk);
    rv0 = n_rv;
    #1 rst = 1'b1;
    #1 chk("t6_rst_outputs", out_vec(), 0);
    cyc(3);
    rst = 1'b0;
    wait_gnt(8, lat);
    chk("t6_regrant", bus.loc_gnt, 1);
    bus.loc_req = 1'b0;
    @(negedge clk);
    chk("t6_rvalid", bus.loc_rvalid, 1);
    chk("t6_rdata", bus.loc_rdata, ref_mem[8'h91]);
    cyc(2);
    @(posedge clk);
    chk("t6_rv_count", n_rv - rv0, 1);
    @(negedge clk);

    // randomized concurrent traffic on disjoint address halves
    bus.i2c_active = 1'b1;
    @(posedge clk);
    gnt0 = n_gnt;
    rv0  = n_rv;
    @(negedge clk);
    nrd = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          i2c_wr(8'($urandom_range(0, 127)), 8'($urandom), 14);
          cyc(int'($urandom_range(0, 10)));
        end
      end
      begin
        logic [7:0] la;
        bit lw;
        int ll;
        for (int k = 0; k < 40; k++) begin
          lw = 1'($urandom);
          la = 8'h80 | 8'($urandom_range(0, 127));
          loc_op(lw, la, 8'($urandom), ll);
          if (!lw) nrd++;
          cyc(int'($urandom_range(0, 4)));
        end
      end
    join
    cyc(20);
    @(posedge clk);
    chk("rnd_gnt_count", n_gnt - gnt0, 40);
    chk("rnd_rvalid_count", n_rv - rv0, nrd);
    chk("rnd_overrun", bus.i2c_wr_overrun, 0);
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      pa = 8'($urandom);
      bus.i2c_addr = pa;
      cyc(12);
      chk("rnd_prefetch", bus.i2c_rdata, ref_mem[pa]);
    end

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_final", mism, 0);
    chk("rm_idle_zero", idle_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
